// File: rtl/nic_node.sv
// ---------------------------------------------------------------------------
// nic_node -- network interface node between a packet source/sink and a
// flit-serial router link.
//
// Outbound path: whole packets (PKT_W bits) are accepted from pkt_in into a
// store of DEPTH packets (a (DEPTH-1)-entry circular FIFO plus a one-packet
// chop register). The sender chops the packet in the chop register into
// FLITS = PKT_W/FLIT_W flits, most significant first, with at least one idle
// cycle between packets.
// Inbound path: flits from the router are collected MSB-first and the
// reassembled packet is presented on pkt_out with a one-cycle strobe.
//
// Optional feature: define NIC_NODE_STATS_EN to add the 16-bit wrap-around
// packet counters tx_count / rx_count.
//
// Ports
//   clock, reset            sole clock (rising edge), async active-high reset
//   pkt_in, pkt_in_avail    packet from the source and its valid
//   cQ_full                 outbound storage full (combinational)
//   pkt_out, pkt_out_avail  reassembled inbound packet and its valid pulse
//   overflow                sticky: a packet was offered while full
//   free_outbound           router can accept a new packet
//   put_outbound            outbound flit valid
//   payload_outbound        outbound flit data
//   free_inbound            node can accept an inbound packet
//   put_inbound             inbound flit valid
//   payload_inbound         inbound flit data
//   tx_count, rx_count      completed packet counters (NIC_NODE_STATS_EN only)
// ---------------------------------------------------------------------------
module nic_node #(
    parameter int NODEID = 0,
    parameter int PKT_W  = 32,
    parameter int FLIT_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              pkt_out_avail,
    output logic              overflow,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [FLIT_W-1:0] payload_outbound,
    output logic              free_inbound,
    input  logic              put_inbound,
    input  logic [FLIT_W-1:0] payload_inbound
`ifdef NIC_NODE_STATS_EN
    ,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count
`endif
);

    localparam int FLITS  = PKT_W / FLIT_W;
    localparam int FDEPTH = DEPTH - 1;
    localparam int PW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int FCW    = $clog2(FDEPTH + 1);
    localparam int OCW    = $clog2(DEPTH + 1);
    localparam int XW     = $clog2(FLITS + 1);
    localparam int RW     = $clog2(FLITS);

    if (NODEID < 0 || NODEID > 15 || FLITS < 2 || PKT_W != FLITS * FLIT_W || DEPTH < 2) begin : g_bad_cfg
        $error("nic_node: invalid parameter set");
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FDEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    function automatic logic [FLIT_W-1:0] flit_of(input logic [PKT_W-1:0] data, input int idx);
        return data[PKT_W-1-idx*FLIT_W -: FLIT_W];
    endfunction

    // ---------------- outbound storage ----------------
    logic [PKT_W-1:0] fifo_mem [FDEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [FCW-1:0]   fifo_cnt;
    logic [PKT_W-1:0] chop_data;
    logic             chop_full;
    logic [OCW-1:0]   occupancy;

    typedef enum logic {IDLE, SEND} tx_state_t;
    tx_state_t        tx_state;
    logic [XW-1:0]    tx_idx;   // index of the next flit to drive

    logic push;
    logic tx_done;
    logic chop_free_next;
    logic refill;
    logic bypass;
    logic fifo_push;

    // The packet in the chop register (including one being sent) counts.
    assign occupancy = OCW'(fifo_cnt) + OCW'(chop_full);
    assign cQ_full   = (occupancy == OCW'(DEPTH));

    assign push           = pkt_in_avail && !cQ_full;
    // tx_done marks the edge that ends the last flit cycle.
    assign tx_done        = (tx_state == SEND) && (tx_idx == XW'(FLITS));
    assign chop_free_next = !chop_full || tx_done;
    // The FIFO head has priority for the chop register so order is kept; a
    // push only bypasses the FIFO when nothing older is waiting.
    assign refill         = chop_free_next && (fifo_cnt != '0);
    assign bypass         = chop_free_next && (fifo_cnt == '0) && push;
    assign fifo_push      = push && !bypass;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            chop_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (pkt_in_avail && cQ_full) overflow <= 1'b1;
            if (refill || bypass) chop_full <= 1'b1;
            else if (tx_done)     chop_full <= 1'b0;
            if (refill)    rd_ptr <= ptr_inc(rd_ptr);
            if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
            case ({fifo_push, refill})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Packet data carries no reset; the valid flags above qualify it.
    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem[wr_ptr] <= pkt_in;
        if (refill)      chop_data <= fifo_mem[rd_ptr];
        else if (bypass) chop_data <= pkt_in;
    end

    // ---------------- sender FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state         <= IDLE;
            tx_idx           <= '0;
            put_outbound     <= 1'b0;
            payload_outbound <= '0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (chop_full && free_outbound) begin
                        tx_state         <= SEND;
                        put_outbound     <= 1'b1;
                        payload_outbound <= flit_of(chop_data, 0);
                        tx_idx           <= XW'(1);
                    end
                end
                SEND: begin
                    // free_outbound is not consulted once a packet has started.
                    if (tx_idx == XW'(FLITS)) begin
                        tx_state         <= IDLE;
                        put_outbound     <= 1'b0;
                        payload_outbound <= '0;
                        tx_idx           <= '0;
                    end else begin
                        payload_outbound <= flit_of(chop_data, int'(tx_idx));
                        tx_idx           <= tx_idx + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [RW-1:0]           rx_idx;
    logic [PKT_W-FLIT_W-1:0] rx_shift;
    logic                    rx_last;

    assign rx_last = put_inbound && (rx_idx == RW'(FLITS - 1));

    always_ff @(posedge clock) begin
        if (put_inbound) rx_shift <= (PKT_W-FLIT_W)'({rx_shift, payload_inbound});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_idx        <= '0;
            free_inbound  <= 1'b1;
            pkt_out       <= '0;
            pkt_out_avail <= 1'b0;
        end else begin
            pkt_out_avail <= 1'b0;
            if (rx_last) begin
                pkt_out       <= {rx_shift, payload_inbound};
                pkt_out_avail <= 1'b1;
                rx_idx        <= '0;
                free_inbound  <= 1'b1;
            end else if (put_inbound) begin
                rx_idx       <= rx_idx + 1'b1;
                free_inbound <= 1'b0;
            end else begin
                // A gap in put_inbound abandons any partial packet.
                rx_idx       <= '0;
                free_inbound <= 1'b1;
            end
        end
    end

`ifdef NIC_NODE_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (tx_done) tx_count <= tx_count + 1'b1;
            if (rx_last) rx_count <= rx_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nic_node.sv
// ---------------------------------------------------------------------------
// tb_nic_node -- self-checking bench for nic_node.
// Instance u_dut uses the default 32/8/4 configuration and is checked every
// cycle against a packet-queue model; instance u_dut64 (64/16/8) is exercised
// with directed sequences including a reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_nic_node;
    localparam int PKT_W = 32, FLIT_W = 8, DEPTH = 4, FLITS = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // default-configuration DUT
    logic              reset = 1'b1;
    logic [PKT_W-1:0]  pkt_in = '0;
    logic              pkt_in_avail = 1'b0;
    logic              cQ_full;
    logic [PKT_W-1:0]  pkt_out;
    logic              pkt_out_avail;
    logic              overflow;
    logic              free_outbound = 1'b0;
    logic              put_outbound;
    logic [FLIT_W-1:0] payload_outbound;
    logic              free_inbound;
    logic              put_inbound = 1'b0;
    logic [FLIT_W-1:0] payload_inbound = '0;
`ifdef NIC_NODE_STATS_EN
    logic [15:0]       tx_count, rx_count, b_tx_count, b_rx_count;
`endif

    // 64/16/8 DUT
    logic        b_reset = 1'b1;
    logic [63:0] b_pkt_in = '0;
    logic        b_pkt_in_avail = 1'b0;
    logic        b_cQ_full;
    logic [63:0] b_pkt_out;
    logic        b_pkt_out_avail;
    logic        b_overflow;
    logic        b_free_outbound = 1'b0;
    logic        b_put_outbound;
    logic [15:0] b_payload_outbound;
    logic        b_free_inbound;
    logic        b_put_inbound = 1'b0;
    logic [15:0] b_payload_inbound = '0;

    nic_node #(.NODEID(3), .PKT_W(PKT_W), .FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset),
        .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail), .cQ_full(cQ_full),
        .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail), .overflow(overflow),
        .free_outbound(free_outbound), .put_outbound(put_outbound),
        .payload_outbound(payload_outbound),
        .free_inbound(free_inbound), .put_inbound(put_inbound),
        .payload_inbound(payload_inbound)
`ifdef NIC_NODE_STATS_EN
        , .tx_count(tx_count), .rx_count(rx_count)
`endif
    );

    nic_node #(.NODEID(9), .PKT_W(64), .FLIT_W(16), .DEPTH(8)) u_dut64 (
        .clock(clock), .reset(b_reset),
        .pkt_in(b_pkt_in), .pkt_in_avail(b_pkt_in_avail), .cQ_full(b_cQ_full),
        .pkt_out(b_pkt_out), .pkt_out_avail(b_pkt_out_avail), .overflow(b_overflow),
        .free_outbound(b_free_outbound), .put_outbound(b_put_outbound),
        .payload_outbound(b_payload_outbound),
        .free_inbound(b_free_inbound), .put_inbound(b_put_inbound),
        .payload_inbound(b_payload_inbound)
`ifdef NIC_NODE_STATS_EN
        , .tx_count(b_tx_count), .rx_count(b_rx_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outbound storage is a queue of packets, head = packet being sent.
    logic [31:0] m_q[$];
    bit          m_sending;
    int          m_pos;          // flit of the head packet on the link now
    bit          m_ovf;
    logic [7:0]  m_rx[$];        // inbound flits collected so far
    logic [31:0] m_pkt_out;
    bit          m_avail;
    int          m_tx_cnt, m_rx_cnt;
    logic [7:0]  obs[$];         // outbound flits seen on the link
    bit          any_full;

    task automatic model_reset();
        m_q.delete(); m_sending = 0; m_pos = 0; m_ovf = 0;
        m_rx.delete(); m_pkt_out = '0; m_avail = 0; m_tx_cnt = 0; m_rx_cnt = 0;
    endtask

    task automatic model_step(input bit pa, input logic [31:0] p, input bit fo,
                              input bit pi, input logic [7:0] pl);
        bit full;
        full = (m_q.size() == DEPTH);
        if (m_sending) begin
            if (m_pos == FLITS - 1) begin
                void'(m_q.pop_front());
                m_sending = 0;
                m_tx_cnt++;
            end else begin
                m_pos++;
            end
        end else if (m_q.size() > 0 && fo) begin
            m_sending = 1;
            m_pos = 0;
        end
        if (pa) begin
            if (full) m_ovf = 1;
            else m_q.push_back(p);
        end
        m_avail = 0;
        if (pi) begin
            m_rx.push_back(pl);
            if (m_rx.size() == FLITS) begin
                m_pkt_out = {m_rx[0], m_rx[1], m_rx[2], m_rx[3]};
                m_avail = 1;
                m_rx.delete();
                m_rx_cnt++;
            end
        end else begin
            m_rx.delete();
        end
    endtask

    task automatic check_outputs();
        logic [31:0] head;
        logic [7:0]  exp_pl;
        exp_pl = 8'h00;
        if (m_sending && m_q.size() > 0) begin
            head = m_q[0];
            exp_pl = head[31-8*m_pos -: 8];
        end
        chk("put_outbound", put_outbound, m_sending);
        chk("payload_outbound", payload_outbound, exp_pl);
        chk("cQ_full", cQ_full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("free_inbound", free_inbound, m_rx.size() == 0);
        chk("pkt_out_avail", pkt_out_avail, m_avail);
        chk("pkt_out", pkt_out, m_pkt_out);
`ifdef NIC_NODE_STATS_EN
        chk("tx_count", tx_count, 16'(m_tx_cnt));
        chk("rx_count", rx_count, 16'(m_rx_cnt));
`endif
        if (put_outbound) obs.push_back(payload_outbound);
        if (cQ_full) any_full = 1;
    endtask

    // Called at a negedge: drive inputs, advance the model over the coming
    // edge, then check at the following negedge.
    task automatic cycle(input bit pa, input logic [31:0] p, input bit fo,
                         input bit pi, input logic [7:0] pl);
        pkt_in_avail = pa; pkt_in = p; free_outbound = fo;
        put_inbound = pi; payload_inbound = pl;
        model_step(pa, p, fo, pi, pl);
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic reset_a();
        @(negedge clock);
        reset = 1'b1;
        pkt_in_avail = 0; free_outbound = 0; put_inbound = 0;
        model_reset();
        #1 check_outputs();
        @(negedge clock);
        reset = 1'b0;
        check_outputs();
        obs.delete();
        any_full = 0;
    endtask

    logic [31:0] pk[5];
    logic [63:0] bp[8];
    logic [15:0] bobs[$];
    int          n;
    bit          pushed;
    bit          bseen;

    initial begin
        // ---------- REQ-027: single packet ----------
        reset_a();
        cycle(1, 32'hA1B2C3D4, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0);
        chk("single_nflits", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("single_f0", obs[0], 8'hA1);
            chk("single_f1", obs[1], 8'hB2);
            chk("single_f2", obs[2], 8'hC3);
            chk("single_f3", obs[3], 8'hD4);
        end
        chk("single_never_full", any_full, 0);

        // ---------- REQ-028: fill, overflow, drain in order ----------
        reset_a();
        for (int i = 0; i < 4; i++) begin
            pk[i] = 32'h10203040 + 32'h01010101 * i;
            cycle(1, pk[i], 0, 0, 0);
        end
        chk("fill_full", cQ_full, 1);
        cycle(1, 32'hDEADBEEF, 0, 0, 0);
        chk("fill_overflow", overflow, 1);
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, 0, 0);
        chk("drain_nflits", obs.size(), 16);
        if (obs.size() == 16)
            for (int k = 0; k < 16; k++) chk("drain_order", obs[k], pk[k/4][31-8*(k%4) -: 8]);
        chk("drain_not_full", cQ_full, 0);

        // ---------- REQ-029: push on the completion edge ----------
        reset_a();
        for (int i = 0; i < 5; i++) pk[i] = $urandom;
        for (int i = 0; i < 3; i++) cycle(1, pk[i], 0, 0, 0);
        pushed = 0;
        n = 0;
        while (!pushed && n < 20) begin
            if (m_sending && m_pos == FLITS - 1) begin
                cycle(1, pk[3], 1, 0, 0);
                pushed = 1;
            end else begin
                cycle(0, 0, 1, 0, 0);
            end
            n++;
        end
        chk("edge_push_done", pushed, 1);
        cycle(1, pk[4], 1, 0, 0);
        chk("edge_push_full", cQ_full, 1);
        for (int i = 0; i < 40; i++) cycle(0, 0, 1, 0, 0);
        chk("edge_nflits", obs.size(), 20);
        if (obs.size() == 20)
            for (int k = 0; k < 20; k++) chk("edge_order", obs[k], pk[k/4][31-8*(k%4) -: 8]);
        chk("edge_no_overflow", overflow, 0);

        // ---------- REQ-030: inbound packet ----------
        reset_a();
        cycle(0, 0, 0, 1, 8'h11);
        chk("rx_busy", free_inbound, 0);
        cycle(0, 0, 0, 1, 8'h22);
        cycle(0, 0, 0, 1, 8'h33);
        cycle(0, 0, 0, 1, 8'h44);
        chk("rx_pkt", pkt_out, 32'h11223344);
        chk("rx_avail", pkt_out_avail, 1);
        chk("rx_free_again", free_inbound, 1);
        cycle(0, 0, 0, 0, 0);
        chk("rx_avail_pulse", pkt_out_avail, 0);
        chk("rx_pkt_hold", pkt_out, 32'h11223344);

        // ---------- REQ-031: aborted inbound packet ----------
        cycle(0, 0, 0, 1, 8'hAA);
        cycle(0, 0, 0, 1, 8'hBB);
        cycle(0, 0, 0, 0, 0);
        chk("abort_free", free_inbound, 1);
        chk("abort_no_avail", pkt_out_avail, 0);
        cycle(0, 0, 0, 1, 8'h55);
        cycle(0, 0, 0, 1, 8'h66);
        cycle(0, 0, 0, 1, 8'h77);
        cycle(0, 0, 0, 1, 8'h88);
        chk("abort_next_pkt", pkt_out, 32'h55667788);
        chk("abort_next_avail", pkt_out_avail, 1);

        // ---------- randomized traffic ----------
        reset_a();
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) < 17, 8'($urandom));

        // ---------- 64/16/8 configuration ----------
        @(negedge clock);
        b_reset = 1'b0;
        chk("b_reset_full", b_cQ_full, 0);
        chk("b_reset_put", b_put_outbound, 0);
        chk("b_reset_free_in", b_free_inbound, 1);
        chk("b_reset_pkt_out", b_pkt_out, 0);
        for (int i = 0; i < 8; i++) begin
            bp[i] = {$urandom, $urandom};
            b_pkt_in = bp[i];
            b_pkt_in_avail = 1'b1;
            b_free_outbound = 1'b0;
            @(negedge clock);
            if (i == 6) chk("b_not_full_at_7", b_cQ_full, 0);
        end
        chk("b_full_at_8", b_cQ_full, 1);
        b_pkt_in_avail = 1'b0;
        b_free_outbound = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (b_put_outbound) bobs.push_back(b_payload_outbound);
        end
        chk("b_nflits", bobs.size(), 32);
        if (bobs.size() == 32)
            for (int k = 0; k < 32; k++) chk("b_order", bobs[k], bp[k/4][63-16*(k%4) -: 16]);
        chk("b_drained", b_cQ_full, 0);
        chk("b_no_overflow", b_overflow, 0);

        // reset during the second flit
        b_pkt_in = 64'h0123_4567_89AB_CDEF;
        b_pkt_in_avail = 1'b1;
        @(negedge clock);
        b_pkt_in_avail = 1'b0;
        n = 0;
        while (!b_put_outbound && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b_start_seen", b_put_outbound, 1);
        chk("b_flit0", b_payload_outbound, 16'h0123);
        @(negedge clock);
        chk("b_flit1", b_payload_outbound, 16'h4567);
        b_reset = 1'b1;
        #1;
        chk("b_rst_put", b_put_outbound, 0);
        chk("b_rst_payload", b_payload_outbound, 0);
        @(negedge clock);
        b_reset = 1'b0;
        bseen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (b_put_outbound) bseen = 1;
        end
        chk("b_no_flits_after_rst", bseen, 0);
        chk("b_empty_after_rst", b_cQ_full, 0);
        chk("b_no_avail", b_pkt_out_avail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nic_node.md
NIC_NODE -- requirements
Module: nic_node

Interface
REQ-001 SHALL have parameter NODEID, default 0: node identifier, 0..15.
REQ-002 SHALL have parameter PKT_W, default 32: packet width in bits, an integer multiple of FLIT_W.
REQ-003 SHALL have parameter FLIT_W, default 8: router link width; FLITS = PKT_W/FLIT_W, at least 2.
REQ-004 SHALL have parameter DEPTH, default 4: total outbound packet storage, at least 2.
REQ-005 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: pkt_in  in  PKT_W  packet from the testbench (TB); pkt_in_avail  in  1  pkt_in valid this cycle; cQ_full  out  1  outbound storage full.
REQ-007 SHALL have ports: pkt_out  out  PKT_W  reassembled inbound packet; pkt_out_avail  out  1  pkt_out valid pulse; overflow  out  1  sticky drop flag.
REQ-008 SHALL have ports: free_outbound  in  1  router can accept; put_outbound  out  1  flit valid; payload_outbound  out  FLIT_W  flit data.
REQ-009 SHALL have ports: free_inbound  out  1  node can accept; put_inbound  in  1  flit valid; payload_inbound  in  FLIT_W  flit data.

Function
REQ-010 SHALL hold up to DEPTH packets in outbound storage: a circular FIFO of DEPTH-1 entries plus a one-packet chop register.
REQ-011 SHALL assert cQ_full combinationally when occupancy, counting the packet currently being sent, equals DEPTH.
REQ-012 SHALL accept pkt_in on any edge where pkt_in_avail=1 and cQ_full=0, incrementing occupancy by one.
REQ-013 SHALL drop pkt_in_avail while cQ_full=1, leave storage unchanged, and set overflow until reset.
REQ-014 SHALL load an accepted packet directly into the chop register when the chop register and FIFO are both empty (bypass); otherwise the packet SHALL go to the FIFO tail.
REQ-015 SHALL refill the chop register from the FIFO head on the edge the sender returns to IDLE; if a push arrives on the same edge, the push SHALL go to the FIFO and both the count and the pointers SHALL stay consistent.
REQ-016 SHALL run the sender state machine IDLE -> SEND -> IDLE; IDLE->SEND when the chop register is full and free_outbound=1.
REQ-017 SHALL, in SEND, assert put_outbound for exactly FLITS consecutive cycles, driving the most significant flit first and ignoring free_outbound once the packet has started.
REQ-018 SHALL, after the last flit, return to IDLE, free the chop register and decrement occupancy; the next packet SHALL start no earlier than one cycle after the last flit (one-cycle gap).
REQ-019 SHALL, in the receiver, assert free_inbound in idle; the first put_inbound flit SHALL deassert free_inbound on the next edge, and flits SHALL be stored most significant first.
REQ-020 SHALL, on the FLITS-th flit, update pkt_out, pulse pkt_out_avail for one cycle on the following edge and reassert free_inbound; pkt_out SHALL hold until the next packet completes.
REQ-021 SHALL, if put_inbound drops mid-packet, discard the partial packet, clear the flit counter and reassert free_inbound.
REQ-022 SHALL wrap FIFO pointers modulo DEPTH-1; pointer and counter widths SHALL be derived with $clog2.

Reset
REQ-023 SHALL asynchronously force: occupancy 0, FIFO and chop register empty, sender IDLE, put_outbound 0, payload_outbound 0, free_inbound 1, pkt_out 0, pkt_out_avail 0, overflow 0, statistics 0.
REQ-024 SHALL abandon any packet in flight when reset asserts mid-transfer, with no further flits after reset deasserts.

Configuration
REQ-025 SHALL, with NIC_NODE_STATS_EN defined, add outputs tx_count and rx_count (16 bits each, wrap-around) that count completed outbound and inbound packets.
REQ-026 SHALL, without NIC_NODE_STATS_EN, omit these ports and counters entirely, with all other behaviour identical.

Verification
REQ-027 SHALL cover: one packet 0xA1B2C3D4 in while idle, free_outbound=1 -> put_outbound high 4 cycles carrying A1, B2, C3, D4; cQ_full never asserts.
REQ-028 SHALL cover: with free_outbound=0, 4 packets pushed -> cQ_full=1; a 5th push -> dropped and overflow=1; then free_outbound=1 -> 4 packets leave in push order with a 1-cycle gap between them.
REQ-029 SHALL cover: a push on the same edge as the last flit of the current packet -> no loss, correct order, occupancy unchanged.
REQ-030 SHALL cover: inbound flits 11, 22, 33, 44 -> pkt_out=0x11223344 and a 1-cycle pkt_out_avail; free_inbound low during the transfer.
REQ-031 SHALL cover: put_inbound dropped after 2 flits -> no pkt_out_avail, free_inbound=1 next cycle, and the next full packet is received correctly.
REQ-032 SHALL cover: reset asserted during the 2nd outbound flit -> put_outbound=0 immediately; PKT_W=64, FLIT_W=16, DEPTH=8 -> 4-flit packets and 8-deep storage.
